matrix_convolution: RTL and testbench

Computes a 3x3 valid-mode 2-D correlation of an 8-bit kernel over a 6x6 8-bit input tile, producing a 4x4 array of 16-bit results. The block is a sequencer and accumulator only. All multiplies go to five external registered multiplier lanes (DSP slices), which the block drives and reads back. It sits between the tile buffer and the result store of the NPU datapath.

---
 rtl/matrix_convolution.sv | 151 +++++++++++++++
 tb/tb_matrix_convolution.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_convolution.sv
// 3x3 valid-mode correlation of a captured 6x6 tile, sequenced over five external
// one-cycle multiplier lanes; two half-steps per output pixel, 36 cycles per tile.
module matrix_convolution (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  input_tile [0:5][0:5],
    input  logic [7:0]  kernel     [0:2][0:2],
    output logic [15:0] c          [0:3][0:3],
    output logic [17:0] dsp_a0     [0:4],
    output logic [17:0] dsp_b0     [0:4],
    input  logic [36:0] dsp_out    [0:4],
    output logic        dsp_ce,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    logic [4:0]  step;
    logic        drain_cnt;
    logic [7:0]  tile_q [0:5][0:5];
    logic [7:0]  kern_q [0:2][0:2];

    logic        issue_vld;
    logic [4:0]  issue_step;
    logic        ret_vld;
    logic [4:0]  ret_step;

    logic [19:0] acc;
    logic [19:0] lane_sum;
    logic [19:0] total;
    logic        unused_hi;

    logic [7:0]  lane_a [0:4];
    logic [7:0]  lane_b [0:4];
    logic [3:0]  tap;
    logic [2:0]  row;
    logic [2:0]  col;

    // Step -> (pixel, half) -> per-lane tap; lane 4 is idle in the second half.
    always_comb begin
        tap = '0;
        row = '0;
        col = '0;
        for (int z = 0; z < 5; z++) begin
            lane_a[z] = '0;
            lane_b[z] = '0;
            if (!step[0] || z < 4) begin
                tap = step[0] ? 4'(z + 5) : 4'(z);
                row = {1'b0, step[4:3]} + 3'(tap / 4'd3);
                col = {1'b0, step[2:1]} + 3'(tap % 4'd3);
                lane_a[z] = tile_q[row][col];
                lane_b[z] = kern_q[2'(tap / 4'd3)][2'(tap % 4'd3)];
            end
        end
    end

    // Products never exceed 65025, so only the low 20 bits of each lane matter.
    always_comb begin
        lane_sum  = '0;
        unused_hi = 1'b0;
        for (int z = 0; z < 5; z++) begin
            lane_sum  = lane_sum + dsp_out[z][19:0];
            unused_hi = unused_hi ^ (^dsp_out[z][36:20]);
        end
        total = acc + lane_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            drain_cnt  <= 1'b0;
            issue_vld  <= 1'b0;
            issue_step <= '0;
            ret_vld    <= 1'b0;
            ret_step   <= '0;
            acc        <= '0;
            dsp_ce     <= 1'b0;
            done       <= 1'b0;
            for (int z = 0; z < 5; z++) begin
                dsp_a0[z] <= '0;
                dsp_b0[z] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    c[i][j] <= '0;
                end
            end
        end else begin
            done      <= 1'b0;
            dsp_ce    <= 1'b0;
            issue_vld <= 1'b0;
            ret_vld   <= issue_vld;
            ret_step  <= issue_step;
            for (int z = 0; z < 5; z++) begin
                dsp_a0[z] <= '0;
                dsp_b0[z] <= '0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        tile_q <= input_tile;
                        kern_q <= kernel;
                        step   <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    for (int z = 0; z < 5; z++) begin
                        dsp_a0[z] <= {10'd0, lane_a[z]};
                        dsp_b0[z] <= {10'd0, lane_b[z]};
                    end
                    dsp_ce     <= 1'b1;
                    issue_vld  <= 1'b1;
                    issue_step <= step;
                    step       <= step + 5'd1;
                    if (step == 5'd31) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    dsp_ce    <= !drain_cnt;
                    drain_cnt <= 1'b1;
                    if (drain_cnt) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Lane results return two edges after issue: first half loads, second half commits.
            if (ret_vld) begin
                if (!ret_step[0]) begin
                    acc <= lane_sum;
                end else begin
                    acc <= total;
                    c[ret_step[4:3]][ret_step[2:1]] <= (total > 20'd65535) ? 16'hFFFF : total[15:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_convolution.sv
// Self-checking bench for matrix_convolution: directed vector table, capture/restart/reset
// sequences and randomized tiles checked against a direct-formula correlation model.
module tb_matrix_convolution;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  input_tile [0:5][0:5];
    logic [7:0]  kernel     [0:2][0:2];
    logic [15:0] c          [0:3][0:3];
    logic [17:0] dsp_a0     [0:4];
    logic [17:0] dsp_b0     [0:4];
    logic [36:0] dsp_out    [0:4];
    logic        dsp_ce;
    logic        done;

    int tests;
    int failed;
    int done_count;
    int done_before;
    int exp_c [0:3][0:3];

    typedef struct {
        string name;
        int    tile_mode;
        int    kern_mode;
        int    exp_c00;
        int    exp_c33;
    } vec_t;

    vec_t vecs [0:3];

    matrix_convolution dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .input_tile (input_tile),
        .kernel     (kernel),
        .c          (c),
        .dsp_a0     (dsp_a0),
        .dsp_b0     (dsp_b0),
        .dsp_out    (dsp_out),
        .dsp_ce     (dsp_ce),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External lanes: one registered multiplier each.
    always @(posedge clk) begin
        for (int z = 0; z < 5; z++) begin
            dsp_out[z] <= 37'(dsp_a0[z]) * 37'(dsp_b0[z]);
        end
    end

    always @(negedge clk) begin
        if (done) done_count++;
    end

    task automatic checkVal(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Tile modes: 0 x+y+1, 1 all 255, 2 all 200, 9 random.
    // Kernel modes: 0 diagonal, 1 top-right only, 2 all 255, 3 centre only, 9 random small, 10 random full.
    task automatic fillInputs(input int tile_mode, input int kern_mode);
        for (int x = 0; x < 6; x++) begin
            for (int y = 0; y < 6; y++) begin
                case (tile_mode)
                    0: input_tile[x][y] = 8'(x + y + 1);
                    1: input_tile[x][y] = 8'd255;
                    2: input_tile[x][y] = 8'd200;
                    default: input_tile[x][y] = 8'($urandom_range(0, 255));
                endcase
            end
        end
        for (int u = 0; u < 3; u++) begin
            for (int v = 0; v < 3; v++) begin
                case (kern_mode)
                    0: kernel[u][v] = (u == v) ? 8'd1 : 8'd0;
                    1: kernel[u][v] = (u == 0 && v == 2) ? 8'd1 : 8'd0;
                    2: kernel[u][v] = 8'd255;
                    3: kernel[u][v] = (u == 1 && v == 1) ? 8'd1 : 8'd0;
                    9: kernel[u][v] = 8'($urandom_range(0, 31));
                    default: kernel[u][v] = 8'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic computeModel();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int u = 0; u < 3; u++) begin
                    for (int v = 0; v < 3; v++) begin
                        s += int'(input_tile[i + u][j + v]) * int'(kernel[u][v]);
                    end
                end
                exp_c[i][j] = (s > 65535) ? 65535 : s;
            end
        end
    endtask

    // Pulses start, optionally disturbs inputs mid-run, and waits (bounded) for done.
    task automatic applyStimulus(input bit zero_after, input bit restart,
                                 output int latency, output bit ce_seen);
        done_before = done_count;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        latency = 0;
        ce_seen = 1'b0;
        while (done !== 1'b1 && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
            if (latency == 1) begin
                ce_seen = dsp_ce;
                if (zero_after) begin
                    for (int x = 0; x < 6; x++)
                        for (int y = 0; y < 6; y++)
                            input_tile[x][y] = 8'd0;
                end
            end
            if (restart && latency == 10) start = 1'b1;
            if (latency == 11) start = 1'b0;
        end
        if (latency >= 100) begin
            tests++;
            failed++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles expected 35", latency);
        end
    endtask

    task automatic checkOutput(input string name, input int latency, input bit ce_seen,
                               input bit use_consts, input int exp00, input int exp33);
        checkVal({name, " latency"}, latency, 35);
        checkVal({name, " dsp_ce_running"}, int'(ce_seen), 1);
        checkVal({name, " dsp_ce_at_done"}, int'(dsp_ce), 0);
        if (use_consts) begin
            checkVal({name, " c00"}, int'(c[0][0]), exp00);
            checkVal({name, " c33"}, int'(c[3][3]), exp33);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                checkVal($sformatf("%s c[%0d][%0d]", name, i, j), int'(c[i][j]), exp_c[i][j]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checkVal({name, " done_pulses"}, done_count - done_before, 1);
    endtask

    initial begin
        int  lat;
        bit  ce_seen;
        int  bad;

        vecs[0] = '{name: "identity",    tile_mode: 0, kern_mode: 0, exp_c00: 9,     exp_c33: 27};
        vecs[1] = '{name: "orientation", tile_mode: 0, kern_mode: 1, exp_c00: 3,     exp_c33: 9};
        vecs[2] = '{name: "saturate",    tile_mode: 1, kern_mode: 2, exp_c00: 65535, exp_c33: 65535};
        vecs[3] = '{name: "centre",      tile_mode: 2, kern_mode: 3, exp_c00: 200,   exp_c33: 200};

        tests      = 0;
        failed     = 0;
        done_count = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        fillInputs(0, 0);

        repeat (3) @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (c[i][j] != 16'd0) bad++;
        checkVal("reset c_nonzero", bad, 0);
        checkVal("reset done", int'(done), 0);
        checkVal("reset dsp_ce", int'(dsp_ce), 0);
        rst_n = 1'b1;
        @(posedge clk);

        for (int k = 0; k < 4; k++) begin
            fillInputs(vecs[k].tile_mode, vecs[k].kern_mode);
            computeModel();
            applyStimulus(1'b0, 1'b0, lat, ce_seen);
            checkOutput(vecs[k].name, lat, ce_seen, 1'b1, vecs[k].exp_c00, vecs[k].exp_c33);
        end

        // Tile zeroed after capture plus a second start mid-run.
        fillInputs(0, 0);
        computeModel();
        applyStimulus(1'b1, 1'b1, lat, ce_seen);
        checkOutput("capture", lat, ce_seen, 1'b1, 9, 27);

        // Reset while step 10 operands are on the lanes.
        fillInputs(0, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (c[i][j] != 16'd0) bad++;
        for (int z = 0; z < 5; z++)
            if (dsp_a0[z] != 18'd0 || dsp_b0[z] != 18'd0) bad++;
        checkVal("midrun_reset nonzero_outputs", bad, 0);
        checkVal("midrun_reset dsp_ce", int'(dsp_ce), 0);
        checkVal("midrun_reset done", int'(done), 0);
        rst_n = 1'b1;
        @(posedge clk);
        fillInputs(0, 1);
        computeModel();
        applyStimulus(1'b0, 1'b0, lat, ce_seen);
        checkOutput("after_reset", lat, ce_seen, 1'b1, 3, 9);

        // Idle lanes stay quiet.
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (dsp_ce !== 1'b0) bad++;
            for (int z = 0; z < 5; z++)
                if (dsp_a0[z] !== 18'd0 || dsp_b0[z] !== 18'd0) bad++;
        end
        checkVal("idle lane_activity", bad, 0);

        for (int r = 0; r < 6; r++) begin
            fillInputs(9, (r % 2 == 0) ? 9 : 10);
            computeModel();
            applyStimulus(1'b0, 1'b0, lat, ce_seen);
            checkOutput($sformatf("random%0d", r), lat, ce_seen, 1'b0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
